// File: rtl/sdram_arbit.sv
// sdram_arbit: grants init/refresh/write/read sequencers one at a time and muxes their commands onto the SDRAM pins.
// Define SDRAM_ARB_RR_EN for round-robin write/read priority; otherwise fixed refresh > write > read.
module sdram_arbit #(
    parameter int DQ_W = 16,
    parameter int A_W  = 13
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            init_end,
    input  logic [3:0]      init_cmd,
    input  logic [1:0]      init_ba,
    input  logic [A_W-1:0]  init_addr,
    input  logic            aref_req,
    input  logic            aref_end,
    input  logic [3:0]      aref_cmd,
    input  logic [1:0]      aref_ba,
    input  logic [A_W-1:0]  aref_addr,
    input  logic            wr_req,
    input  logic            wr_end,
    input  logic [3:0]      wr_cmd,
    input  logic [1:0]      wr_ba,
    input  logic [A_W-1:0]  wr_addr,
    input  logic            wr_sdram_en,
    input  logic [DQ_W-1:0] wr_sdram_data,
    input  logic            rd_req,
    input  logic            rd_end,
    input  logic [3:0]      rd_cmd,
    input  logic [1:0]      rd_ba,
    input  logic [A_W-1:0]  rd_addr,
    output logic            aref_en,
    output logic            wr_en,
    output logic            rd_en,
    output logic            sdram_cke,
    output logic            sdram_cs_n,
    output logic            sdram_ras_n,
    output logic            sdram_cas_n,
    output logic            sdram_we_n,
    output logic [1:0]      sdram_ba,
    output logic [A_W-1:0]  sdram_addr,
    output logic [DQ_W-1:0] sdram_dq_out,
    output logic            sdram_dq_oe
);
    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;
    state_t         state;
    logic           pick_wr;
    logic [3:0]     cmd;
`ifdef SDRAM_ARB_RR_EN
    logic rr_ptr;
    // rr_ptr=1 means read currently has priority over write
    assign pick_wr = wr_req & (~rd_req | ~rr_ptr);
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n)
            rr_ptr <= 1'b0;
        else if (state == ARBIT && !aref_req && (wr_req || rd_req))
            rr_ptr <= ~rr_ptr;
`else
    assign pick_wr = wr_req;
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state)
                INIT:  if (init_end) state <= ARBIT;
                ARBIT: begin
                    if (aref_req) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (pick_wr) begin
                        state <= WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_req) begin
                        state <= READ;
                        rd_en <= 1'b1;
                    end
                end
                AREF:  if (aref_end) begin
                    state   <= ARBIT;
                    aref_en <= 1'b0;
                end
                WRITE: if (wr_end) begin
                    state <= ARBIT;
                    wr_en <= 1'b0;
                end
                READ:  if (rd_end) begin
                    state <= ARBIT;
                    rd_en <= 1'b0;
                end
                default: state <= INIT;
            endcase
        end
    end
    always_comb begin
        cmd        = 4'b0111;
        sdram_ba   = 2'b11;
        sdram_addr = '1;
        case (state)
            INIT:  begin cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
            AREF:  begin cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
            WRITE: begin cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
            READ:  begin cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
            default: ;
        endcase
    end
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = (state == WRITE) & wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed checks of grant order, command muxing, DQ enable and async reset for sdram_arbit.
module tb_sdram_arbit;
    localparam int DQ_W = 16;
    localparam int A_W  = 13;
    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic            init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
    logic [3:0]      init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]      init_ba, aref_ba, wr_ba, rd_ba;
    logic [A_W-1:0]  init_addr, aref_addr, wr_addr, rd_addr;
    logic [DQ_W-1:0] wr_sdram_data;
    logic            aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]      sdram_ba;
    logic [A_W-1:0]  sdram_addr;
    logic [DQ_W-1:0] sdram_dq_out;
    logic            sdram_dq_oe;
    int              n_assert = 0;
    int              n_fail = 0;
    logic            m_ptr = 1'b0;

    sdram_arbit #(.DQ_W(DQ_W), .A_W(A_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] c, input logic [1:0] b, input logic [A_W-1:0] a);
        chk({tag, ".cmd"}, 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(c));
        chk({tag, ".ba"}, 32'(sdram_ba), 32'(b));
        chk({tag, ".addr"}, 32'(sdram_addr), 32'(a));
    endtask

    task automatic chk_en(input string tag, input logic a, input logic w, input logic r);
        chk({tag, ".en"}, 32'({aref_en, wr_en, rd_en}), 32'({a, w, r}));
    endtask

    // predicts write/read winner from ARBIT, steps one edge, checks the grant
    task automatic grant_chk(input string tag);
        logic pw;
        pw = wr_req & (~rd_req | ~m_ptr);
        step();
        chk_en(tag, 1'b0, pw, ~pw);
        if (pw) chk_pins(tag, wr_cmd, wr_ba, wr_addr);
        else    chk_pins(tag, rd_cmd, rd_ba, rd_addr);
`ifdef SDRAM_ARB_RR_EN
        m_ptr = ~m_ptr;
`endif
    endtask

    initial begin
        sys_rst_n = 1'b0; init_end = 1'b0;
        aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
        wr_sdram_en = 0; wr_sdram_data = 16'hA5A5;
        init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
        aref_cmd = 4'b0001; aref_ba = 2'b10; aref_addr = 13'h0AAA;
        wr_cmd   = 4'b0100; wr_ba   = 2'b00; wr_addr   = 13'h0123;
        rd_cmd   = 4'b0011; rd_ba   = 2'b01; rd_addr   = 13'h0456;
        #1;
        chk_pins("rst", 4'b0010, 2'b01, 13'h0400);
        chk_en("rst", 0, 0, 0);
        chk("rst.cke", 32'(sdram_cke), 32'd1);
        chk("rst.oe", 32'(sdram_dq_oe), 32'd0);
        step(); sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("init.cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h2);
            chk_en("init", 0, 0, 0);
        end
        init_end = 1'b1;
        step();
        chk_pins("arbit", 4'b0111, 2'b11, 13'h1FFF);
        chk_en("arbit", 0, 0, 0);
        // read alone
        rd_req = 1'b1;
        grant_chk("rd_grant");
        rd_req = 1'b0; rd_cmd = 4'b0101; #1;
        chk_pins("rd_track", 4'b0101, 2'b01, 13'h0456);
        chk("rd.oe", 32'(sdram_dq_oe), 32'd0);
        rd_end = 1'b1;
        step(); rd_end = 1'b0;
        chk_en("rd_done", 0, 0, 0);
        chk_pins("rd_done", 4'b0111, 2'b11, 13'h1FFF);
        // write alone, DQ enable, refresh arriving mid-burst
        wr_req = 1'b1;
        grant_chk("wr_grant");
        chk("wr.oe0", 32'(sdram_dq_oe), 32'd0);
        chk("wr.dq0", 32'(sdram_dq_out), 32'd0);
        wr_sdram_en = 1'b1; #1;
        chk("wr.oe1", 32'(sdram_dq_oe), 32'd1);
        chk("wr.dq1", 32'(sdram_dq_out), 32'hA5A5);
        aref_req = 1'b1;
        step();
        chk_en("no_preempt", 0, 1, 0);
        wr_end = 1'b1; wr_req = 1'b0;
        step(); wr_end = 1'b0; wr_sdram_en = 1'b0;
        chk_en("wr_done", 0, 0, 0);
        chk_pins("wr_done", 4'b0111, 2'b11, 13'h1FFF);
        chk("wr_done.oe", 32'(sdram_dq_oe), 32'd0);
        step();
        chk_en("aref_after_wr", 1, 0, 0);
        chk_pins("aref_after_wr", 4'b0001, 2'b10, 13'h0AAA);
        aref_req = 1'b0; aref_end = 1'b1;
        step(); aref_end = 1'b0;
        chk_en("aref_done", 0, 0, 0);
        // all three simultaneously
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        chk_en("all3_aref", 1, 0, 0);
        rd_end = 1'b1; wr_end = 1'b1; step(); rd_end = 1'b0; wr_end = 1'b0;
        chk_en("stray_end", 1, 0, 0);
        aref_req = 1'b0; aref_end = 1'b1;
        step(); aref_end = 1'b0;
        chk_en("all3_gap", 0, 0, 0);
        grant_chk("all3_second");
        if (wr_en) begin wr_end = 1'b1; step(); wr_end = 1'b0; end
        else       begin rd_end = 1'b1; step(); rd_end = 1'b0; end
        chk_en("all3_gap2", 0, 0, 0);
        grant_chk("both_held");
        if (wr_en) begin wr_end = 1'b1; step(); wr_end = 1'b0; end
        else       begin rd_end = 1'b1; step(); rd_end = 1'b0; end
        wr_req = 1'b0;
        grant_chk("rd_last");
        // READ ignores write data enable, then reset mid-burst
        wr_sdram_en = 1'b1; #1;
        chk("rd.oe_wr_en", 32'(sdram_dq_oe), 32'd0);
        sys_rst_n = 1'b0; #1;
        chk_en("rst_mid", 0, 0, 0);
        chk_pins("rst_mid", 4'b0010, 2'b01, 13'h0400);
        chk("rst_mid.oe", 32'(sdram_dq_oe), 32'd0);
        step();
        chk_pins("rst_hold", 4'b0010, 2'b01, 13'h0400);
        sys_rst_n = 1'b1; rd_req = 1'b0; wr_sdram_en = 1'b0;
        step();
        chk_pins("post_rst", 4'b0111, 2'b11, 13'h1FFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
